tiny_host_bridge: RTL and testbench

//   Host-side stage directly upstream of the tiny pairing core's operand RAM port
//   (sel/addr/w/data in, out back). Packs 198-bit GF(3^97) elements from a 32-bit

---
 rtl/tiny_host_bridge.sv | 150 +++++++++++++++
 tb/tb_tiny_host_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_host_bridge.sv
// Host-side bridge for the pairing core's operand RAM: packs 7 host words into one
// 198-bit element write and unpacks one element read into 7 host words.
module tiny_host_bridge #(
  parameter int W      = 198,
  parameter int BW     = 32,
  parameter int NW     = 7,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          bad_trit,
  output logic          busy,
  output logic          ram_sel,
  output logic          ram_w,
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_data,
  input  logic [W-1:0]  ram_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // cmd_ready, in_ready and out_valid are registered and only change on that edge.

  localparam int TOP = W - BW * (NW - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    RDREQ = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t                 state;
  logic [2:0]             cnt;
  logic [3:0]             lat_cnt;
  logic [BW*(NW-1)-1:0]   rd_sr;
  logic                   has_bad;

  always_comb begin
    has_bad = 1'b0;
    for (int i = 0; i < W / 2; i++) begin
      if (ram_data[2*i +: 2] == 2'b11) has_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lat_cnt   <= 4'd0;
      rd_sr     <= '0;
      cmd_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      bad_trit  <= 1'b0;
      busy      <= 1'b0;
      ram_sel   <= 1'b0;
      ram_w     <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            ram_addr  <= cmd_addr;
            cnt       <= 3'd0;
            if (cmd_write) begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end else begin
              state   <= RDREQ;
              ram_sel <= 1'b1;
              lat_cnt <= 4'd0;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < NW - 1; k++) begin
              if (cnt == 3'(k)) ram_data[k*BW +: BW] <= in_data;
            end
            // The last word only carries the top TOP bits of the element.
            if (cnt == 3'(NW - 1)) begin
              ram_data[W-1:BW*(NW-1)] <= in_data[TOP-1:0];
              in_ready <= 1'b0;
              ram_sel  <= 1'b1;
              ram_w    <= 1'b1;
              cnt      <= 3'd0;
              state    <= WRITE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          ram_sel   <= 1'b0;
          ram_w     <= 1'b0;
          if (has_bad) bad_trit <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        RDREQ: begin
          // Core output is valid RD_LAT edges after the request, sampled one edge later.
          if (lat_cnt == 4'(RD_LAT)) begin
            ram_sel   <= 1'b0;
            rd_sr     <= {{(BW*NW-W){1'b0}}, ram_out[W-1:BW]};
            out_data  <= ram_out[BW-1:0];
            out_valid <= 1'b1;
            cnt       <= 3'd0;
            state     <= SEND;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt == 3'(NW - 1)) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_data <= rd_sr[BW-1:0];
              rd_sr    <= rd_sr >> BW;
              cnt      <= cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_host_bridge.sv
// Randomised bench for tiny_host_bridge with a core RAM model and an element-level
// reference memory; RAM writes and read words are checked against expected queues.
module tb_tiny_host_bridge;
  localparam int W  = 198;
  localparam int BW = 32;
  localparam int NW = 7;
  localparam int AW = 7;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          cmd_ready, in_ready, out_valid, bad_trit, busy, ram_sel, ram_w;
  logic [BW-1:0] out_data;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  ram_out = '0;

  tiny_host_bridge dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bad_trit(bad_trit), .busy(busy),
    .ram_sel(ram_sel), .ram_w(ram_w), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_out(ram_out)
  );

  // core RAM model: one-cycle registered read
  logic [W-1:0] core_mem [0:127];
  always @(posedge clk) begin
    if (ram_sel && ram_w) core_mem[ram_addr] <= ram_data;
    else if (ram_sel) ram_out <= core_mem[ram_addr];
  end

  // reference model and scoreboard
  logic [W-1:0]    ref_mem [0:127];
  bit              ref_bad = 1'b0;
  logic [AW+W-1:0] exp_ram_q[$];
  logic [BW-1:0]   exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] e;
    logic [1:0] t;
    for (int i = 0; i < W / 2; i++) begin
      t = 2'($urandom_range(0, 2));
      e[2*i +: 2] = t;
    end
    return e;
  endfunction

  function automatic bit has_11(input logic [W-1:0] e);
    for (int i = 0; i < W / 2; i++) if (e[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  // RAM write monitor
  always @(negedge clk) begin
    if (ram_w) begin
      logic [AW+W-1:0] x;
      if (exp_ram_q.size() == 0) check("ram_w_unexpected", 1, 0);
      else begin
        x = exp_ram_q.pop_front();
        check("ram_addr", ram_addr, x[AW+W-1:W]);
        check("ram_data", ram_data, x[W-1:0]);
        check("ram_sel_on_write", ram_sel, 1);
      end
    end
  end

  task automatic check_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_bad_trit", bad_trit, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_sel", ram_sel, 0);
    check("rst_ram_w", ram_w, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
  endtask

  // driver tasks: all called and returning at a falling edge
  task automatic send_cmd(input bit wr, input logic [AW-1:0] a);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] e,
                          input logic [BW-1:0] junk, input bit stalls, input int abort_after);
    logic [BW-1:0] wd [NW];
    int n;
    for (int k = 0; k < NW - 1; k++) wd[k] = e[k*BW +: BW];
    wd[NW-1] = (junk & 32'hFFFF_FFC0) | {26'b0, e[W-1:BW*(NW-1)]};
    if (abort_after >= NW) begin
      exp_ram_q.push_back({a, e});
      ref_mem[a] = e;
    end
    in_valid = 1'b1; in_data = $urandom;
    send_cmd(1'b1, a);
    in_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (k == abort_after) begin
        reset = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        reset = 1'b0;
        ref_bad = 1'b0;
        @(negedge clk);
        return;
      end
      if (stalls) repeat ($urandom_range(0, 2)) @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b1; in_data = wd[k];
      @(negedge clk);
      in_valid = 1'b0; in_data = $urandom;
    end
    n = 0;
    while (!ram_w && n < 20) begin @(negedge clk); n++; end
    if (!stalls) check("write_latency", n, 0);
    @(negedge clk);
    check("ram_w_one_cycle", ram_w, 0);
    ref_bad = ref_bad | has_11(e);
    check("bad_trit", bad_trit, ref_bad);
    check("busy_after_write", busy, 0);
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic do_read(input logic [AW-1:0] a, input int mode);
    int n, beats, cyc;
    bit phase;
    for (int k = 0; k < NW - 1; k++) exp_q.push_back(ref_mem[a][k*BW +: BW]);
    exp_q.push_back({26'b0, ref_mem[a][W-1:BW*(NW-1)]});
    send_cmd(1'b0, a);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("read_latency", n, 2);
    beats = 0; cyc = 0; phase = 1'b1;
    while (beats < NW && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
      phase = ~phase;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_q[0]);
      if (mode == 1 && beats == NW - 1) check("word6_upper_zero", out_data[31:6], 0);
      if (out_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("read_beats", beats, NW);
    check("out_valid_after", out_valid, 0);
    check("busy_after_read", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] e;
    for (int i = 0; i < 128; i++) begin core_mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    @(negedge clk);
    check_reset();

    do_write(7'd0, 198'h115a25886512165251569195908560596a6695612620504191, 32'h0, 1'b0, NW);
    do_write(7'd3, 198'h1559546442405a181195655549614540592955a15a26984015, $urandom, 1'b1, NW);
    do_read(7'd3, 0);
    do_read(7'd0, 2);
    do_read(7'd3, 1);

    e = rand_elem();
    e[W-1:BW*(NW-1)] = 6'h15;
    do_write(7'd9, e, 32'hFFFF_FFC0, 1'b0, NW);
    do_read(7'd9, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) do_write(7'($urandom_range(0, 15)), rand_elem(), $urandom, 1'b1, NW);
      else do_read(7'($urandom_range(0, 15)), 2);
    end

    e = rand_elem();
    e[31:0] = 32'h0000_0003;
    do_write(7'd10, e, $urandom, 1'b1, NW);
    do_write(7'd11, rand_elem(), $urandom, 1'b0, NW);
    do_read(7'd10, 0);

    do_write(7'd5, rand_elem(), $urandom, 1'b0, NW);
    do_write(7'd5, rand_elem(), $urandom, 1'b0, 4);
    check_reset();
    do_read(7'd5, 2);
    check("ram_q_drained", exp_ram_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
